// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter from NUM_PORTS cache-side requesters onto one memory port, one transaction in flight.
// Optional per-port completion counters on grant_cnt: define ARB_PERF_CNT_EN.
module mem_port_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 32,
  parameter int LINE_W    = 256
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS-1:0]        req_read,
  input  logic [NUM_PORTS-1:0]        req_write,
  input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
  input  logic [NUM_PORTS*LINE_W-1:0] req_wdata,
  output logic [LINE_W-1:0]           req_rdata,
  output logic [NUM_PORTS-1:0]        req_resp,
  output logic                        mem_read,
  output logic                        mem_write,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [LINE_W-1:0]           mem_wdata,
  input  logic [LINE_W-1:0]           mem_rdata,
  input  logic                        mem_resp,
  output logic [NUM_PORTS*32-1:0]     grant_cnt,
  output logic [1:0]                  dbg_state
);

  // Handshake: a requester holds req_read/req_write (and addr/wdata) until its one-cycle
  // req_resp pulse; the memory strobe is held with stable addr/wdata until a one-cycle mem_resp.

  localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [PTR_W:0]   NP_EXT = (PTR_W+1)'(NUM_PORTS);
  localparam logic [PTR_W-1:0] LAST   = PTR_W'(NUM_PORTS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [PTR_W-1:0]     r_rr_ptr;
  logic [PTR_W-1:0]     r_grant;
  logic                 r_mem_read;
  logic                 r_mem_write;
  logic [ADDR_W-1:0]    r_mem_addr;
  logic [LINE_W-1:0]    r_mem_wdata;
  logic [LINE_W-1:0]    r_req_rdata;
  logic [NUM_PORTS-1:0] r_req_resp;

  logic [NUM_PORTS-1:0] w_req;
  logic [NUM_PORTS-1:0] w_onehot;
  logic                 w_found;
  logic [PTR_W-1:0]     w_grant_idx;
  logic [PTR_W:0]       w_sum;
  logic [ADDR_W-1:0]    w_addr_arr  [NUM_PORTS];
  logic [LINE_W-1:0]    w_wdata_arr [NUM_PORTS];

  assign w_req    = req_read | req_write;
  assign w_onehot = {{(NUM_PORTS-1){1'b0}}, 1'b1} << r_grant;

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack
    assign w_addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
    assign w_wdata_arr[gi] = req_wdata[gi*LINE_W +: LINE_W];
  end

  // First requesting port at or after r_rr_ptr; the sum is folded so it never reaches NUM_PORTS.
  always_comb begin
    w_found     = 1'b0;
    w_grant_idx = '0;
    w_sum       = '0;
    for (int off = 0; off < NUM_PORTS; off++) begin
      w_sum = {1'b0, r_rr_ptr} + (PTR_W+1)'(off);
      if (w_sum >= NP_EXT) w_sum = w_sum - NP_EXT;
      if (!w_found && w_req[w_sum[PTR_W-1:0]]) begin
        w_found     = 1'b1;
        w_grant_idx = w_sum[PTR_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_found) w_next = S_BUSY;
      S_BUSY:  if (mem_resp) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rr_ptr    <= '0;
      r_grant     <= '0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_req_rdata <= '0;
      r_req_resp  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_grant     <= w_grant_idx;
            r_mem_addr  <= w_addr_arr[w_grant_idx];
            r_mem_wdata <= w_wdata_arr[w_grant_idx];
            r_mem_write <= req_write[w_grant_idx];
            r_mem_read  <= ~req_write[w_grant_idx];
          end
        end
        S_BUSY: begin
          if (mem_resp) begin
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            if (!r_mem_write) r_req_rdata <= mem_rdata;
            r_req_resp  <= w_onehot;
          end
        end
        S_DONE: begin
          r_req_resp <= '0;
          r_rr_ptr   <= (r_grant == LAST) ? '0 : r_grant + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef ARB_PERF_CNT_EN
  logic [31:0] r_cnt [NUM_PORTS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_PORTS; i++) r_cnt[i] <= '0;
    end else if (r_state == S_DONE && r_cnt[r_grant] != 32'hFFFF_FFFF) begin
      r_cnt[r_grant] <= r_cnt[r_grant] + 32'd1;
    end
  end

  for (genvar gc = 0; gc < NUM_PORTS; gc++) begin : g_cnt
    assign grant_cnt[gc*32 +: 32] = r_cnt[gc];
  end
`else
  assign grant_cnt = '0;
`endif

  assign mem_read  = r_mem_read;
  assign mem_write = r_mem_write;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign req_rdata = r_req_rdata;
  assign req_resp  = r_req_resp;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter (3 ports): random requesters and memory, transaction-level model
// checked every cycle, plus directed ordering, latency, reset and counter scenarios.
module tb_mem_port_arbiter;

  localparam int NP = 3;
  localparam int AW = 32;
  localparam int LW = 256;

  logic              clk = 1'b0;
  logic              rst;
  logic [NP-1:0]     req_read, req_write;
  logic [NP*AW-1:0]  req_addr;
  logic [NP*LW-1:0]  req_wdata;
  logic [LW-1:0]     req_rdata;
  logic [NP-1:0]     req_resp;
  logic              mem_read, mem_write;
  logic [AW-1:0]     mem_addr;
  logic [LW-1:0]     mem_wdata;
  logic [LW-1:0]     mem_rdata;
  logic              mem_resp;
  logic [NP*32-1:0]  grant_cnt;
  logic [1:0]        dbg_state;

  mem_port_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .LINE_W(LW)) dut (
    .clk(clk), .rst(rst),
    .req_read(req_read), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_rdata(req_rdata), .req_resp(req_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .grant_cnt(grant_cnt), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset control ----------------
  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- stimulus state ----------------
  logic          p_pend [NP];
  logic          p_rd   [NP];
  logic          p_wr   [NP];
  logic [AW-1:0] p_addr [NP];
  logic [LW-1:0] p_wd   [NP];
  bit            quiet    = 1'b1;
  bit            auto_on  = 1'b0;
  int            auto_pct = 0;
  int            fixed_dly = 0;
  bit            use_aa   = 1'b0;
  logic [LW-1:0] aa_line  = {32{8'hAA}};

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    for (int k = 0; k < LW/32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic issue(input int p, input logic rd, input logic wr,
                       input logic [AW-1:0] a, input logic [LW-1:0] d);
    p_rd[p] = rd; p_wr[p] = wr; p_addr[p] = a; p_wd[p] = d; p_pend[p] = 1'b1;
  endtask

  // Requesters: hold each request until its req_resp pulse has been seen.
  initial begin
    logic got [NP];
    int   op;
    req_read = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    for (int i = 0; i < NP; i++) begin p_pend[i] = 1'b0; got[i] = 1'b0; end
    forever begin
      @(negedge clk);
      for (int i = 0; i < NP; i++) if (req_resp[i]) got[i] = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < NP; i++) begin
        if (quiet || got[i]) p_pend[i] = 1'b0;
        got[i] = 1'b0;
        if (!quiet && auto_on && !p_pend[i] && $urandom_range(99) < auto_pct) begin
          op = $urandom_range(2);
          p_rd[i] = (op != 1); p_wr[i] = (op != 0);
          p_addr[i] = $urandom; p_wd[i] = rand_line(); p_pend[i] = 1'b1;
        end
        req_read[i]  = p_pend[i] & p_rd[i];
        req_write[i] = p_pend[i] & p_wr[i];
        req_addr[i*AW +: AW]  = p_addr[i];
        req_wdata[i*LW +: LW] = p_wd[i];
      end
    end
  end

  // Memory: respond dly cycles after the strobe is first seen; stray mem_resp right after a completion.
  initial begin
    int cnt = 0; int dly = 1; bit responded = 1'b0; bit nxt;
    mem_resp = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      nxt = 1'b0;
      if (quiet || !rst) begin
        cnt = 0; responded = 1'b0;
      end else if (mem_read || mem_write) begin
        cnt++;
        if (!responded && cnt == dly) begin nxt = 1'b1; responded = 1'b1; end
      end else begin
        cnt = 0; responded = 1'b0;
        dly = (fixed_dly != 0) ? fixed_dly : $urandom_range(1, 3);
        if (req_resp != '0 && $urandom_range(3) == 0) nxt = 1'b1;
      end
      @(posedge clk); #1;
      mem_resp  = nxt;
      mem_rdata = use_aa ? aa_line : rand_line();
    end
  end

  // ---------------- reference model + per-cycle compare ----------------
  int            m_ph = 0;          // 0 waiting for a grant, 1 memory access, 2 completion
  int            m_rr = 0, m_g = 0;
  logic          m_wr;
  logic [AW-1:0] m_addr;
  logic [LW-1:0] m_wd, m_rdata;
  logic [31:0]   m_cnt [NP];

  logic [7:0]    served_q[$];
  logic [7:0]    exp_q[$];
  logic [AW-1:0] last_w_addr, last_r_addr;
  logic [LW-1:0] last_w_data, last_rdata;
  logic [NP-1:0] last_resp;
  int            rd_cycles = 0;

  initial begin
    logic [NP-1:0]    e_resp;
    logic [NP*32-1:0] e_cnt;
    bit found; int j;
    m_rdata = '0;
    for (int i = 0; i < NP; i++) m_cnt[i] = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        m_ph = 0; m_rr = 0; m_rdata = '0;
        for (int i = 0; i < NP; i++) m_cnt[i] = '0;
        chk("reset_strobes_resp", LW'({mem_read, mem_write, req_resp}), '0);
        chk("reset_req_rdata", req_rdata, '0);
        chk("reset_mem_addr", LW'(mem_addr), '0);
        chk("reset_grant_cnt", LW'(grant_cnt), '0);
      end else begin
        e_resp = (m_ph == 2) ? (NP'(1) << m_g) : '0;
        e_cnt  = '0;
`ifdef ARB_PERF_CNT_EN
        for (int i = 0; i < NP; i++) e_cnt[i*32 +: 32] = m_cnt[i];
`endif
        chk("mem_read",  LW'(mem_read),  LW'(m_ph == 1 && !m_wr));
        chk("mem_write", LW'(mem_write), LW'(m_ph == 1 && m_wr));
        chk("req_resp",  LW'(req_resp),  LW'(e_resp));
        chk("grant_cnt", LW'(grant_cnt), LW'(e_cnt));
        if (m_ph == 1) chk("mem_addr", LW'(mem_addr), LW'(m_addr));
        if (m_ph == 1 && m_wr) chk("mem_wdata", mem_wdata, m_wd);
        if (m_ph == 2) chk("req_rdata", req_rdata, m_rdata);
        // observations used by the directed scenarios
        if (mem_write) begin last_w_addr = mem_addr; last_w_data = mem_wdata; end
        if (mem_read)  begin last_r_addr = mem_addr; rd_cycles++; end
        if (req_resp != '0) begin
          for (int i = 0; i < NP; i++) if (req_resp[i]) served_q.push_back(8'(i));
          last_resp = req_resp; last_rdata = req_rdata;
        end
        // advance the model with this cycle's inputs
        if (m_ph == 0) begin
          found = 1'b0;
          for (int off = 0; off < NP; off++) begin
            j = (m_rr + off) % NP;
            if (!found && (req_read[j] || req_write[j])) begin found = 1'b1; m_g = j; end
          end
          if (found) begin
            m_wr = req_write[m_g]; m_addr = req_addr[m_g*AW +: AW];
            m_wd = req_wdata[m_g*LW +: LW]; m_ph = 1;
          end
        end else if (m_ph == 1) begin
          if (mem_resp) begin
            if (!m_wr) m_rdata = mem_rdata;
            m_ph = 2;
          end
        end else begin
          m_rr = (m_g + 1) % NP;
          if (m_cnt[m_g] != 32'hFFFF_FFFF) m_cnt[m_g] = m_cnt[m_g] + 32'd1;
          m_ph = 0;
        end
      end
    end
  end

  // ---------------- scenario helpers ----------------
  task automatic wait_idle(input string nm);
    int t = 0; bit busy = 1'b1;
    while (busy && t < 400) begin
      @(negedge clk); t++;
      busy = 1'b0;
      for (int i = 0; i < NP; i++) if (p_pend[i]) busy = 1'b1;
    end
    n_checks++;
    if (busy) begin
      n_fail++;
      $display("FAIL %s: requests still pending after %0d cycles, required all served", nm, t);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic cmp_order(input string nm);
    while (exp_q.size() > 0) begin
      if (served_q.size() == 0) chk(nm, LW'(8'hFF), LW'(exp_q.pop_front()));
      else chk(nm, LW'(served_q.pop_front()), LW'(exp_q.pop_front()));
    end
    served_q.delete();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int t; int stale; logic [NP*32-1:0] e_cnt;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk); #2; rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_reset_idle", LW'({mem_read, mem_write, req_resp}), '0);
    quiet = 1'b0;

    // Port 0 read and port 1 write together, pointer at 0: read first, then the write.
    served_q.delete();
    issue(0, 1'b1, 1'b0, 32'h0000_3000, rand_line());
    issue(1, 1'b0, 1'b1, 32'h0000_2000, {32{8'h55}});
    exp_q.push_back(8'd0); exp_q.push_back(8'd1);
    wait_idle("simul_rw");
    cmp_order("simul_rw_order");
    chk("simul_w_addr", LW'(last_w_addr), LW'(32'h0000_2000));
    chk("simul_w_data", last_w_data, {32{8'h55}});

    // Pointer now 2: ports 2 and 0 -> 2 then 0 (wrap), leaving the pointer at 1.
    issue(2, 1'b1, 1'b0, 32'h0000_5000, rand_line());
    issue(0, 1'b0, 1'b1, 32'h0000_6000, rand_line());
    exp_q.push_back(8'd2); exp_q.push_back(8'd0);
    wait_idle("wrap");
    cmp_order("wrap_order");
    chk("model_rr_after_wrap", LW'(m_rr), LW'(1));

    // Pointer 1: ports 0 and 1 (read+write -> write) -> 1 first.
    issue(0, 1'b1, 1'b0, 32'h0000_7000, rand_line());
    issue(1, 1'b1, 1'b1, 32'h0000_4000, rand_line());
    exp_q.push_back(8'd1); exp_q.push_back(8'd0);
    wait_idle("ptr1");
    cmp_order("ptr1_order");
    chk("both_ops_write_wins", LW'(last_w_addr), LW'(32'h0000_4000));

    // Single read on port 1, memory answers in the third strobe cycle with 0xAA..AA.
    fixed_dly = 2; use_aa = 1'b1; rd_cycles = 0; last_resp = '0;
    issue(1, 1'b1, 1'b0, 32'h0000_1040, rand_line());
    wait_idle("single_read");
    chk("read_strobe_cycles", LW'(rd_cycles), LW'(3));
    chk("read_addr", LW'(last_r_addr), LW'(32'h0000_1040));
    chk("read_resp", LW'(last_resp), LW'(3'b010));
    chk("read_rdata", last_rdata, {32{8'hAA}});
    fixed_dly = 0; use_aa = 1'b0;
    served_q.delete();

    // All ports continuously requesting from pointer 2: 2,0,1,2,0,1.
    auto_pct = 100; auto_on = 1'b1;
    t = 0;
    while (served_q.size() < 6 && t < 200) begin @(negedge clk); t++; end
    auto_on = 1'b0;
    wait_idle("all_ports");
    for (int k = 0; k < 6; k++) exp_q.push_back(8'((k + 2) % NP));
    while (served_q.size() > 6) void'(served_q.pop_back());
    cmp_order("fair_order");

    // Asynchronous reset in the middle of a memory access.
    fixed_dly = 8;
    issue(0, 1'b1, 1'b0, 32'h0000_8000, rand_line());
    t = 0;
    while (!mem_read && t < 50) begin @(negedge clk); t++; end
    chk("busy_before_reset", LW'(mem_read), LW'(1));
    @(posedge clk); #3;
    rst = 1'b0; quiet = 1'b1;
    #1;
    chk("async_rst_mem_read", LW'(mem_read), '0);
    chk("async_rst_mem_write", LW'(mem_write), '0);
    chk("async_rst_req_resp", LW'(req_resp), '0);
    repeat (2) @(negedge clk);
    @(posedge clk); #2; rst = 1'b1;
    stale = 0;
    repeat (6) begin @(negedge clk); if (req_resp != '0 || mem_read || mem_write) stale++; end
    chk("no_stale_after_reset", LW'(stale), '0);
    fixed_dly = 0; quiet = 1'b0;
    served_q.delete();

    // Five transactions on port 1 after reset.
    for (int k = 0; k < 5; k++) begin
      t = $urandom_range(1);
      issue(1, t[0], ~t[0], $urandom, rand_line());
      wait_idle("perf_txn");
    end
`ifdef ARB_PERF_CNT_EN
    e_cnt = {32'd0, 32'd5, 32'd0};
`else
    e_cnt = '0;
`endif
    chk("perf_cnt_port1", LW'(grant_cnt), LW'(e_cnt));

    // Randomized traffic against the model.
    auto_pct = 25; auto_on = 1'b1;
    repeat (1500) @(negedge clk);
    auto_on = 1'b0;
    wait_idle("random_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Parametrised N-port arbiter between cache-side requesters (icache, dcache, future prefetch/victim buffers) and the single physical memory port below the cpu top.
- Successor to the fixed two-port icache/dcache arbiter.
- Round-robin fair grant, one outstanding transaction, registered memory-side outputs.
- Sits between the caches and external memory.

Parameters:
- NUM_PORTS, 2, number of requester ports (2..8).
- ADDR_W, 32, address width.
- LINE_W, 256, data width per transfer (one cache line).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low (asserted when 0).
- req_read  in  NUM_PORTS  per-port read request, held until that port's req_resp.
- req_write  in  NUM_PORTS  per-port write request, held until that port's req_resp.
- req_addr  in  NUM_PORTS*ADDR_W  per-port address, port i at bits [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_PORTS*LINE_W  per-port write data, same packing.
- req_rdata  out  LINE_W  read data, shared by all ports, valid with req_resp.
- req_resp  out  NUM_PORTS  one-hot, one-cycle completion pulse.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  LINE_W  memory write data.
- mem_rdata  in  LINE_W  memory read data, valid with mem_resp.
- mem_resp  in  1  memory completion, one cycle.
- grant_cnt  out  NUM_PORTS*32  per-port completed-transaction counters (see Optional Feature).

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, rr_ptr=0; all outputs 0. Applies immediately, including mid-transaction; the in-flight transaction is dropped with no req_resp.
- FSM IDLE -> BUSY -> DONE -> IDLE.
- IDLE:
  - A port is requesting if req_read[i] or req_write[i].
  - Grant goes to the first requesting port at or after rr_ptr, wrapping at NUM_PORTS-1 -> 0.
  - On grant: latch grant index, addr, wdata and op into registers; go to BUSY.
  - No request: stay in IDLE.
- Op select: if a port asserts both read and write, write wins.
- BUSY:
  - mem_read or mem_write (from the latched op), mem_addr and mem_wdata driven from registers. Strobe rises the cycle after the grant.
  - Outputs are held stable until mem_resp.
  - On mem_resp: capture mem_rdata into req_rdata (reads only; writes leave req_rdata unchanged), drop the strobe next cycle, go to DONE.
- DONE (one cycle):
  - req_resp[grant]=1 for exactly this cycle; all other req_resp bits 0.
  - rr_ptr <= (grant+1) mod NUM_PORTS.
  - Requests are ignored this cycle so a requester can deassert. Next state IDLE.
- Minimum latency: request seen in IDLE at cycle t -> strobe at t+1 -> mem_resp at t+k (k>=2) -> req_resp at t+k+1. Back-to-back grants are separated by one IDLE cycle.
- Changes to requests while BUSY have no effect; they are not re-sampled until IDLE.
- mem_resp outside BUSY is ignored.
- Requests arriving in DONE are sampled in the following IDLE cycle.
- rr_ptr wraps modulo NUM_PORTS. For non-power-of-2 NUM_PORTS, rr_ptr never holds an index >= NUM_PORTS.

Optional Feature:
- Macro: ARB_PERF_CNT_EN.
- Defined:
  - grant_cnt slice i increments by 1 in each DONE cycle where grant==i.
  - Saturates at 0xFFFFFFFF.
  - Cleared by reset.
- Not defined: grant_cnt is tied to 0, no counter flops are synthesised, and port width is unchanged.

Test Plan:
- NUM_PORTS=2, single read on port 1 at addr 0x0000_1040, memory responds 3 cycles after the strobe with 0xAA..AA -> mem_read=1 with mem_addr=0x1040 for 3 cycles; req_resp=2'b10 one cycle after mem_resp; req_rdata=0xAA..AA.
- NUM_PORTS=4, all four ports request continuously -> grant order 0,1,2,3,0; no port served twice before the others; req_resp is one-hot each time.
- Port 0 read and port 1 write (addr 0x2000, wdata 0x55..55) asserted in the same IDLE cycle with rr_ptr=0 -> read serviced first, then mem_write=1 with mem_addr=0x2000 and mem_wdata=0x55..55.
- NUM_PORTS=3, ports 2 and 0 requesting with rr_ptr=2 -> port 2 granted, then port 0 (wrap); rr_ptr returns to 1.
- rst driven low during BUSY, between clock edges -> mem_read, mem_write and req_resp are 0 immediately. After release with no requests, stays in IDLE and no stale req_resp is issued.
- ARB_PERF_CNT_EN defined, 5 transactions on port 1 -> grant_cnt[63:32]=5 and grant_cnt[31:0]=0. Undefined -> grant_cnt=0 throughout.
